// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment display driver.
package display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  // Double-dabble correction step applied to one BCD digit before each shift.
  function automatic logic [3:0] add3_nibble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph (bit0=a .. bit6=g).
import display_pkg::*;

module hex_to_seg7 (
  input  logic [3:0] nib,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_driver.sv
// Drives HEX7..HEX0 from a 32-bit value in hex, or in decimal via a
// multi-cycle double-dabble converter, with leading-zero blanking and overflow dashes.
import display_pkg::*;

module hex_display_driver #(
  parameter int DIGITS        = 8,
  parameter int BCD_DIGITS    = 10,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_i,
  input  logic        dec_mode_i,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic        busy_o,
  output logic        ovf_o
);

  localparam int BCD_W = BCD_DIGITS * 4;

  state_t                   state;
  logic [31:0]              shown_val, bin_sr;
  logic                     shown_mode, shown_valid, hex_upd;
  logic [BCD_W-1:0]         bcd_sr, bcd_adj;
  logic [4:0]               cnt;
  logic [DIGITS-1:0][3:0]   dig;
  logic [DIGITS-1:0][6:0]   glyph, seg_d, hex_q;
  logic                     trigger, ovf_d;

  assign trigger = (state == IDLE) &&
                   (!shown_valid || value_i != shown_val || dec_mode_i != shown_mode);
  assign ovf_d   = (state == DONE) && (bcd_sr[BCD_W-1:32] != '0);
  assign dig     = (state == DONE) ? bcd_sr[31:0] : shown_val;

  genvar g;
  generate
    for (g = 0; g < BCD_DIGITS; g++) begin : g_adj
      assign bcd_adj[4*g +: 4] = add3_nibble(bcd_sr[4*g +: 4]);
    end
    for (g = 0; g < DIGITS; g++) begin : g_seg
      hex_to_seg7 u_seg (.nib(dig[g]), .seg(glyph[g]));
    end
  endgenerate

  // Overflow wins over blanking; zero run from the top blanks until a nonzero digit.
  always_comb begin
    logic run;
    seg_d = '0;
    run   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run && (dig[i] == 4'd0);
      if (ovf_d)
        seg_d[i] = SEG_DASH;
      else if (BLANK_LEADING != 0 && i != 0 && run)
        seg_d[i] = SEG_BLANK;
      else
        seg_d[i] = glyph[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shown_val   <= '0;
      shown_mode  <= 1'b0;
      shown_valid <= 1'b0;
      hex_upd     <= 1'b0;
      bin_sr      <= '0;
      bcd_sr      <= '0;
      cnt         <= '0;
      busy_o      <= 1'b0;
      ovf_o       <= 1'b0;
      hex_q       <= {DIGITS{SEG_BLANK}};
    end else begin
      hex_upd <= 1'b0;
      if (hex_upd || state == DONE) begin
        hex_q <= seg_d;
        ovf_o <= ovf_d;
      end
      case (state)
        IDLE: if (trigger) begin
          shown_val  <= value_i;
          shown_mode <= dec_mode_i;
          if (dec_mode_i) begin
            state  <= LOAD;
            busy_o <= 1'b1;
          end else begin
            hex_upd     <= 1'b1;
            shown_valid <= 1'b1;
          end
        end
        LOAD: begin
          bin_sr <= shown_val;
          bcd_sr <= '0;
          cnt    <= '0;
          busy_o <= 1'b1;
          state  <= SHIFT;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE: begin
          busy_o      <= 1'b0;
          shown_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule
